// File: rtl/lean_pkg.sv
// Shared state/mode types and default constants for lean_profile_gen.
// Checker logic in the top level is built only when LEAN_CHECK_EN is defined.
package lean_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_RAMP_UP,
        S_RETURN,
        S_RAMP_DN,
        S_FIN
    } leanState_e;

    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DN   = 2'd1,
        MODE_BOTH = 2'd2
    } leanMode_e;

    localparam int          DEFAULT_STEP = 1000;
    localparam logic [15:0] DEFAULT_TOL  = 16'h1000;

    // The reserved encoding 3 plays the full up-then-down profile.
    function automatic leanMode_e decodeMode(input logic [1:0] raw);
        leanMode_e m;
        case (raw)
            2'd0:    m = MODE_UP;
            2'd1:    m = MODE_DN;
            default: m = MODE_BOTH;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/abs_sat.sv
// Saturating absolute value of a signed word; the most-negative input maps
// to the largest positive value instead of wrapping back to itself.
module abs_sat #(
    parameter int MON_W = 16
) (
    input  logic signed [MON_W-1:0] x_i,
    output logic        [MON_W-1:0] abs_o
);

    localparam logic [MON_W-1:0] MOST_NEG = {1'b1, {(MON_W-1){1'b0}}};
    localparam logic [MON_W-1:0] POS_MAX  = {1'b0, {(MON_W-1){1'b1}}};

    always_comb begin
        abs_o = $unsigned(x_i);
        if ($unsigned(x_i) == MOST_NEG) begin
            abs_o = POS_MAX;
        end else if (x_i[MON_W-1]) begin
            abs_o = $unsigned(-x_i);
        end
    end

endmodule

// File: rtl/lean_profile_gen.sv
// Rider-lean staircase sequencer with zero-lean balance checks on the mon channels.
// Define LEAN_CHECK_EN to build the checker; otherwise fail/fail_chan are tied low.
module lean_profile_gen
    import lean_pkg::*;
#(
    parameter int               LEAN_W    = 14,
    parameter int               STEP_SIZE = DEFAULT_STEP,
    parameter int               NUM_STEPS = 8,
    parameter int               DWELL_W   = 20,
    parameter int               NUM_MON   = 3,
    parameter int               MON_W     = 16,
    parameter logic [MON_W-1:0] TOL       = MON_W'(DEFAULT_TOL)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [1:0]                mode,
    input  logic [DWELL_W-1:0]        dwell,
    input  logic [NUM_MON*MON_W-1:0]  mon,
    output logic signed [LEAN_W-1:0]  lean,
    output logic [4:0]                step_idx,
    output logic                      step_strobe,
    output logic                      busy,
    output logic                      done,
    output logic                      fail,
    output logic [NUM_MON-1:0]        fail_chan
);

    localparam int PW = LEAN_W + 8;
    localparam logic signed [PW-1:0] LEAN_MAX = PW'((64'sd1 <<< (LEAN_W - 1)) - 64'sd1);
    localparam logic signed [PW-1:0] LEAN_MIN = ~LEAN_MAX;

    leanState_e         state_q, state_d;
    leanMode_e          mode_q, mode_d;
    logic [DWELL_W-1:0] dwellLen_q, dwellLen_d;
    logic [DWELL_W-1:0] dwellCnt_q, dwellCnt_d;
    logic [4:0]         stepIdx_q, stepIdx_d;

    logic               inPhase;
    logic               phaseLast;
    logic               lastStep;
    logic               zeroCheck;
    logic               clearFail;
    logic [PW-1:0]      leanMag;
    logic signed [PW-1:0] leanProd;

    assign inPhase   = (state_q == S_SETTLE) || (state_q == S_RAMP_UP) ||
                       (state_q == S_RETURN) || (state_q == S_RAMP_DN);
    assign phaseLast = inPhase && (dwellCnt_q == (dwellLen_q - DWELL_W'(1)));
    assign lastStep  = (stepIdx_q == 5'(NUM_STEPS));
    assign zeroCheck = phaseLast && ((state_q == S_SETTLE) || (state_q == S_RETURN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_BOTH;
            dwellLen_q <= DWELL_W'(1);
            dwellCnt_q <= '0;
            stepIdx_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            dwellLen_q <= dwellLen_d;
            dwellCnt_q <= dwellCnt_d;
            stepIdx_q  <= stepIdx_d;
        end
    end

    // Abort overrides everything except reset; a start seen together with abort is dropped.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        dwellLen_d = dwellLen_q;
        dwellCnt_d = dwellCnt_q;
        stepIdx_d  = stepIdx_q;
        clearFail  = 1'b0;

        if (abort) begin
            state_d    = S_IDLE;
            dwellCnt_d = '0;
            stepIdx_d  = '0;
        end else begin
            if (inPhase) begin
                dwellCnt_d = phaseLast ? '0 : dwellCnt_q + DWELL_W'(1);
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d    = S_SETTLE;
                        mode_d     = decodeMode(mode);
                        dwellLen_d = (dwell == '0) ? DWELL_W'(1) : dwell;
                        dwellCnt_d = '0;
                        stepIdx_d  = '0;
                        clearFail  = 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (phaseLast) begin
                        stepIdx_d = 5'd1;
                        state_d   = (mode_q == MODE_DN) ? S_RAMP_DN : S_RAMP_UP;
                    end
                end
                S_RAMP_UP: begin
                    if (phaseLast) begin
                        if (!lastStep) begin
                            stepIdx_d = stepIdx_q + 5'd1;
                        end else begin
                            stepIdx_d = '0;
                            state_d   = (mode_q == MODE_BOTH) ? S_RETURN : S_FIN;
                        end
                    end
                end
                S_RETURN: begin
                    if (phaseLast) begin
                        stepIdx_d = 5'd1;
                        state_d   = S_RAMP_DN;
                    end
                end
                S_RAMP_DN: begin
                    if (phaseLast) begin
                        if (!lastStep) begin
                            stepIdx_d = stepIdx_q + 5'd1;
                        end else begin
                            stepIdx_d = '0;
                            state_d   = S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Lean is formed at LEAN_W+8 bits so large steps clip instead of wrapping.
    always_comb begin
        leanMag  = PW'(stepIdx_q) * PW'(STEP_SIZE);
        leanProd = (state_q == S_RAMP_DN) ? -$signed(leanMag) : $signed(leanMag);
        if ((state_q != S_RAMP_UP) && (state_q != S_RAMP_DN)) begin
            lean = '0;
        end else if (leanProd > LEAN_MAX) begin
            lean = LEAN_MAX[LEAN_W-1:0];
        end else if (leanProd < LEAN_MIN) begin
            lean = LEAN_MIN[LEAN_W-1:0];
        end else begin
            lean = leanProd[LEAN_W-1:0];
        end
    end

    assign step_idx    = stepIdx_q;
    assign step_strobe = phaseLast;
    assign busy        = inPhase;
    assign done        = (state_q == S_FIN);

`ifdef LEAN_CHECK_EN
    logic [NUM_MON-1:0] failChan_q, failChan_d;
    logic [NUM_MON-1:0] overTol;

    for (genvar g = 0; g < NUM_MON; g++) begin : g_chk
        logic [MON_W-1:0] magnitude;
        abs_sat #(.MON_W(MON_W)) u_abs (
            .x_i   (mon[g*MON_W +: MON_W]),
            .abs_o (magnitude)
        );
        assign overTol[g] = (magnitude > TOL);
    end

    // Violations accumulate until the next accepted start; abort keeps them.
    always_comb begin
        failChan_d = failChan_q;
        if (clearFail) begin
            failChan_d = '0;
        end else if (!abort && zeroCheck) begin
            failChan_d = failChan_q | overTol;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            failChan_q <= '0;
        end else begin
            failChan_q <= failChan_d;
        end
    end

    assign fail_chan = failChan_q;
    assign fail      = |failChan_q;
`else
    logic unusedMon;
    assign unusedMon = ^{mon, clearFail, zeroCheck};
    assign fail_chan = '0;
    assign fail      = 1'b0;
`endif

endmodule

// File: tb/tb_lean_profile_gen.sv
// Self-checking bench for lean_profile_gen: a cycle-list reference model built
// from the profile rules, randomized mon/mode/dwell, plus directed edge scenarios.
module tb_lean_profile_gen;

`ifdef LEAN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               start2 = 1'b0;
    logic               abort = 1'b0;
    logic [1:0]         mode = 2'd0;
    logic [19:0]        dwell = 20'd1;
    logic [47:0]        mon = '0;

    logic signed [13:0] lean, lean2;
    logic [4:0]         stepIdx, stepIdx2;
    logic               stepStrobe, stepStrobe2;
    logic               busy, busy2;
    logic               done, done2;
    logic               fail, fail2;
    logic [2:0]         failChan, failChan2;

    int vectors = 0;
    int errors  = 0;

    int expLean[$];
    int expStep[$];
    bit expStrobe[$];
    bit expBusy[$];
    bit expDone[$];
    bit expZero[$];

    always #5 clk = ~clk;

    lean_profile_gen dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .dwell(dwell), .mon(mon), .lean(lean), .step_idx(stepIdx),
        .step_strobe(stepStrobe), .busy(busy), .done(done), .fail(fail),
        .fail_chan(failChan)
    );

    lean_profile_gen #(.STEP_SIZE(3000), .NUM_STEPS(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort), .mode(mode),
        .dwell(dwell), .mon(mon), .lean(lean2), .step_idx(stepIdx2),
        .step_strobe(stepStrobe2), .busy(busy2), .done(done2), .fail(fail2),
        .fail_chan(failChan2)
    );

    function automatic int satLean(input int v);
        if (v > 8191)  return 8191;
        if (v < -8192) return -8192;
        return v;
    endfunction

    function automatic void pushCycle(input int l, input int s, input bit st,
                                      input bit b, input bit d, input bit z);
        expLean.push_back(l);
        expStep.push_back(s);
        expStrobe.push_back(st);
        expBusy.push_back(b);
        expDone.push_back(d);
        expZero.push_back(z);
    endfunction

    // One entry per clock after the start edge, ending with the FIN cycle.
    function automatic void buildExpected(input int md, input int dw, input int ss, input int ns);
        int d;
        int m;
        d = (dw == 0) ? 1 : dw;
        m = (md == 3) ? 2 : md;
        expLean.delete(); expStep.delete(); expStrobe.delete();
        expBusy.delete(); expDone.delete(); expZero.delete();
        for (int k = 0; k < d; k++) pushCycle(0, 0, k == d - 1, 1, 0, 1);
        if (m != 1)
            for (int s = 1; s <= ns; s++)
                for (int k = 0; k < d; k++) pushCycle(satLean(s * ss), s, k == d - 1, 1, 0, 0);
        if (m == 2)
            for (int k = 0; k < d; k++) pushCycle(0, 0, k == d - 1, 1, 0, 1);
        if (m != 0)
            for (int s = 1; s <= ns; s++)
                for (int k = 0; k < d; k++) pushCycle(satLean(-s * ss), s, k == d - 1, 1, 0, 0);
        pushCycle(0, 0, 0, 0, 1, 0);
    endfunction

    function automatic logic [2:0] violations(input logic [47:0] m);
        logic [2:0] v;
        int x;
        int a;
        v = '0;
        if (CHK_EN) begin
            for (int i = 0; i < 3; i++) begin
                x = int'($signed(m[i*16 +: 16]));
                a = (x < 0) ? -x : x;
                if (a > 32767) a = 32767;
                if (a > 4096) v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic [47:0] randMon();
        logic [47:0] m;
        logic [15:0] v;
        m = '0;
        for (int i = 0; i < 3; i++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: v = 16'h0000;
                3:       v = 16'($urandom_range(0, 8192)) - 16'd4096;
                4:       v = 16'h1001;
                5:       v = 16'h8000;
                6:       v = 16'hF000;
                default: v = 16'($urandom);
            endcase
            m[i*16 +: 16] = v;
        end
        return m;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (int'(lean) !== 0)   begin errors++; $display("[TB] FAIL reset_lean got %0d exp 0", lean); end
        vectors++; if (stepIdx !== 5'd0)   begin errors++; $display("[TB] FAIL reset_step got %0d exp 0", stepIdx); end
        vectors++; if (stepStrobe !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobe got %b exp 0", stepStrobe); end
        vectors++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        vectors++; if (done !== 1'b0)      begin errors++; $display("[TB] FAIL reset_done got %b exp 0", done); end
        vectors++; if (fail !== 1'b0 || failChan !== 3'b000)
            begin errors++; $display("[TB] FAIL reset_fail got %b/%b exp 0/000", fail, failChan); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_profiles();
        int md, dw, doneAt;
        logic [2:0] mask;
        for (int it = 0; it < 7; it++) begin
            if (it == 0)      begin md = 2; dw = 4; end
            else if (it == 1) begin md = 3; dw = 0; end
            else begin md = $urandom_range(0, 3); dw = $urandom_range(0, 5); end
            buildExpected(md, dw, 1000, 8);
            mode = 2'(md); dwell = 20'(dw); mon = '0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            mask = '0;
            doneAt = -1;
            for (int c = 0; c < expLean.size(); c++) begin
                vectors++; if (int'(lean) !== expLean[c])
                    begin errors++; $display("[TB] FAIL prof%0d_lean c=%0d got %0d exp %0d", it, c, lean, expLean[c]); end
                vectors++; if (int'(stepIdx) !== expStep[c])
                    begin errors++; $display("[TB] FAIL prof%0d_step c=%0d got %0d exp %0d", it, c, stepIdx, expStep[c]); end
                vectors++; if (stepStrobe !== expStrobe[c])
                    begin errors++; $display("[TB] FAIL prof%0d_strobe c=%0d got %b exp %b", it, c, stepStrobe, expStrobe[c]); end
                vectors++; if (busy !== expBusy[c])
                    begin errors++; $display("[TB] FAIL prof%0d_busy c=%0d got %b exp %b", it, c, busy, expBusy[c]); end
                vectors++; if (done !== expDone[c])
                    begin errors++; $display("[TB] FAIL prof%0d_done c=%0d got %b exp %b", it, c, done, expDone[c]); end
                vectors++; if (failChan !== mask || fail !== (|mask))
                    begin errors++; $display("[TB] FAIL prof%0d_fail c=%0d got %b/%b exp %b/%b", it, c, fail, failChan, |mask, mask); end
                if (done === 1'b1 && doneAt < 0) doneAt = c + 1;
                mon = (it == 0) ? '0 : randMon();
                if (expStrobe[c] && expZero[c]) mask |= violations(mon);
                @(negedge clk);
            end
            vectors++; if (busy !== 1'b0 || int'(lean) !== 0 || done !== 1'b0 || failChan !== mask)
                begin errors++; $display("[TB] FAIL prof%0d_idle got busy=%b lean=%0d done=%b chan=%b exp 0/0/0/%b", it, busy, lean, done, failChan, mask); end
            if (it == 0) begin
                vectors++; if (doneAt !== 73)
                    begin errors++; $display("[TB] FAIL done_latency got %0d exp 73", doneAt); end
            end
        end
    endtask

    task automatic test_abort();
        int doneSeen;
        buildExpected(0, 3, 1000, 8);
        mode = 2'd0; dwell = 20'd3; mon = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            vectors++; if (int'(lean) !== expLean[c])
                begin errors++; $display("[TB] FAIL abort_lean c=%0d got %0d exp %0d", c, lean, expLean[c]); end
            if (c == 3) begin
                vectors++; if (failChan !== (CHK_EN ? 3'b010 : 3'b000) || fail !== CHK_EN)
                    begin errors++; $display("[TB] FAIL chan1_tol got %b/%b exp %b/%b", fail, failChan, CHK_EN, CHK_EN ? 3'b010 : 3'b000); end
            end
            if (c == 9) begin
                vectors++; if (stepIdx !== 5'd3 || int'(lean) !== 3000)
                    begin errors++; $display("[TB] FAIL abort_at_step3 got step=%0d lean=%0d exp 3/3000", stepIdx, lean); end
                abort = 1'b1;
            end
            mon = (c < 3) ? {16'h0000, 16'h1001, 16'h0000} : 48'h0;
            @(negedge clk);
        end
        abort = 1'b0;
        vectors++; if (int'(lean) !== 0 || stepIdx !== 5'd0 || busy !== 1'b0 || done !== 1'b0)
            begin errors++; $display("[TB] FAIL abort_idle got lean=%0d step=%0d busy=%b done=%b exp 0/0/0/0", lean, stepIdx, busy, done); end
        vectors++; if (failChan !== (CHK_EN ? 3'b010 : 3'b000))
            begin errors++; $display("[TB] FAIL abort_keeps_fail got %b exp %b", failChan, CHK_EN ? 3'b010 : 3'b000); end
        doneSeen = 0;
        for (int k = 0; k < 5; k++) begin
            if (done === 1'b1 || busy === 1'b1) doneSeen++;
            @(negedge clk);
        end
        vectors++; if (doneSeen !== 0)
            begin errors++; $display("[TB] FAIL abort_no_done got %0d active cycles exp 0", doneSeen); end
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        vectors++; if (busy !== 1'b0 || failChan !== (CHK_EN ? 3'b010 : 3'b000))
            begin errors++; $display("[TB] FAIL start_abort_same got busy=%b chan=%b exp 0/%b", busy, failChan, CHK_EN ? 3'b010 : 3'b000); end
        mode = 2'd0; dwell = 20'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++; if (fail !== 1'b0 || failChan !== 3'b000 || busy !== 1'b1)
            begin errors++; $display("[TB] FAIL restart_clears got fail=%b chan=%b busy=%b exp 0/000/1", fail, failChan, busy); end
        mon = {16'hF000, 16'h0000, 16'h8000};
        @(negedge clk);
        mon = '0;
        vectors++; if (failChan !== (CHK_EN ? 3'b001 : 3'b000))
            begin errors++; $display("[TB] FAIL abs_sat_chan got %b exp %b", failChan, CHK_EN ? 3'b001 : 3'b000); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_saturation();
        int maxL, minL;
        buildExpected(2, 2, 3000, 4);
        mode = 2'd2; dwell = 20'd2; mon = '0; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        maxL = 0; minL = 0;
        for (int c = 0; c < expLean.size(); c++) begin
            vectors++; if (int'(lean2) !== expLean[c] || int'(stepIdx2) !== expStep[c] || done2 !== expDone[c])
                begin errors++; $display("[TB] FAIL sat_cycle c=%0d got lean=%0d step=%0d done=%b exp %0d/%0d/%b", c, lean2, stepIdx2, done2, expLean[c], expStep[c], expDone[c]); end
            if (int'(lean2) > maxL) maxL = int'(lean2);
            if (int'(lean2) < minL) minL = int'(lean2);
            @(negedge clk);
        end
        vectors++; if (maxL !== 8191 || minL !== -8192)
            begin errors++; $display("[TB] FAIL sat_limits got %0d/%0d exp 8191/-8192", maxL, minL); end
    endtask

    task automatic test_reset_mid();
        mode = 2'd1; dwell = 20'd3; mon = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            mon = (c < 3) ? {16'h0000, 16'h0000, 16'h2000} : 48'h0;
            @(negedge clk);
        end
        mon = '0;
        vectors++; if (int'(lean) !== -2000 || fail !== CHK_EN)
            begin errors++; $display("[TB] FAIL mid_ramp_dn got lean=%0d fail=%b exp -2000/%b", lean, fail, CHK_EN); end
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (int'(lean) !== 0 || stepIdx !== 5'd0 || stepStrobe !== 1'b0 || busy !== 1'b0 ||
                       done !== 1'b0 || fail !== 1'b0 || failChan !== 3'b000)
            begin errors++; $display("[TB] FAIL mid_reset got lean=%0d step=%0d strobe=%b busy=%b done=%b fail=%b chan=%b exp all 0",
                                     lean, stepIdx, stepStrobe, busy, done, fail, failChan); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_profiles();
        test_abort();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
